// File: rtl/branch_predictor.sv
// Direct-mapped branch predictor: 2-bit saturating direction counters, a target per entry,
// a registered one-cycle lookup, resolve-stage training and a misprediction redirect pulse.
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lk_valid,
  input  logic [31:0]      lk_pc,
  output logic             pred_valid,
  output logic             pred_taken,
  output logic [31:0]      pred_target,
  input  logic             rs_valid,
  input  logic [31:0]      rs_pc,
  input  logic             rs_taken,
  input  logic [31:0]      rs_target,
  input  logic [31:0]      rs_fallthrough,
  input  logic             rs_pred_taken,
  input  logic [31:0]      rs_pred_target,
  output logic             mispredict,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] mp_count
);

  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = 31 - IDX;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             r_valid  [ENTRIES];
  logic [TAG_W-1:0] r_tag    [ENTRIES];
  logic [31:0]      r_target [ENTRIES];
  logic [1:0]       r_ctr    [ENTRIES];

  logic             r_pred_valid;
  logic             r_pred_taken;
  logic [31:0]      r_pred_target;
  logic             r_mp;
  logic [31:0]      r_redirect;
  logic [CNT_W-1:0] r_mp_count;

  logic [IDX-1:0]   w_lk_idx;
  logic [TAG_W-1:0] w_lk_tag;
  logic             w_lk_taken;
  logic [IDX-1:0]   w_rs_idx;
  logic [TAG_W-1:0] w_rs_tag;
  logic             w_rs_hit;
  logic             w_mp;
  logic [1:0]       w_ctr_next;
  logic             w_unused;

  // Bit 0 of a halfword-aligned PC carries no information.
  assign w_unused   = ^{lk_pc[0], rs_pc[0]};

  assign w_lk_idx   = lk_pc[IDX:1];
  assign w_lk_tag   = lk_pc[31:IDX+1];
  assign w_lk_taken = lk_valid && r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag)
                      && r_ctr[w_lk_idx][1];

  assign w_rs_idx   = rs_pc[IDX:1];
  assign w_rs_tag   = rs_pc[31:IDX+1];
  assign w_rs_hit   = r_valid[w_rs_idx] && (r_tag[w_rs_idx] == w_rs_tag);

  assign w_mp = rs_valid && ((rs_taken != rs_pred_taken) ||
                             (rs_taken && (rs_pred_target != rs_target)));

  always_comb begin
    w_ctr_next = r_ctr[w_rs_idx];
    if (rs_taken) begin
      if (r_ctr[w_rs_idx] != 2'b11) w_ctr_next = r_ctr[w_rs_idx] + 2'b01;
    end else begin
      if (r_ctr[w_rs_idx] != 2'b00) w_ctr_next = r_ctr[w_rs_idx] - 2'b01;
    end
  end

  // Lookup reads the table as it stood before this edge's update (read-before-write).
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= 2'b01;
      end
      r_pred_valid  <= 1'b0;
      r_pred_taken  <= 1'b0;
      r_pred_target <= '0;
      r_mp          <= 1'b0;
      r_redirect    <= '0;
      r_mp_count    <= '0;
    end else begin
      r_pred_valid  <= lk_valid;
      r_pred_taken  <= w_lk_taken;
      r_pred_target <= w_lk_taken ? r_target[w_lk_idx] : '0;
      r_mp          <= w_mp;
      r_redirect    <= w_mp ? (rs_taken ? rs_target : rs_fallthrough) : '0;
      if (w_mp && (r_mp_count != '1)) r_mp_count <= r_mp_count + CNT_ONE;
      if (rs_valid) begin
        if (w_rs_hit) begin
          r_ctr[w_rs_idx] <= w_ctr_next;
          if (rs_taken) r_target[w_rs_idx] <= rs_target;
        end else if (rs_taken) begin
          r_valid[w_rs_idx]  <= 1'b1;
          r_tag[w_rs_idx]    <= w_rs_tag;
          r_target[w_rs_idx] <= rs_target;
          r_ctr[w_rs_idx]    <= 2'b10;
        end
      end
    end
  end

  assign pred_valid  = r_pred_valid;
  assign pred_taken  = r_pred_taken;
  assign pred_target = r_pred_target;
  assign mispredict  = r_mp;
  assign redirect_pc = r_redirect;
  assign mp_count    = r_mp_count;

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter ENTRIES, default 16, meaning number of direct-mapped table entries; SHALL be a power of two in the range 4..64.
REQ-002 Parameter CNT_W, default 16, meaning width of the misprediction statistics counter.
REQ-003 Port clk  input  1  meaning single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  meaning reset, synchronous and active-high.
REQ-005 Port lk_valid  input  1  meaning fetch-stage lookup request.
REQ-006 Port lk_pc  input  32  meaning PC of the looked-up instruction, halfword aligned (compressed-capable).
REQ-007 Port pred_valid  output  1  meaning prediction result valid.
REQ-008 Port pred_taken  output  1  meaning predicted direction.
REQ-009 Port pred_target  output  32  meaning predicted target; 0 when pred_taken=0.
REQ-010 Port rs_valid  input  1  meaning branch resolved this cycle (execute stage).
REQ-011 Port rs_pc  input  32  meaning PC of the resolved branch.
REQ-012 Port rs_taken  input  1  meaning actual outcome (comparator branch flag).
REQ-013 Port rs_target  input  32  meaning computed taken target.
REQ-014 Port rs_fallthrough  input  32  meaning PC+2 or PC+4 of the branch.
REQ-015 Port rs_pred_taken  input  1  meaning direction that was predicted for this branch.
REQ-016 Port rs_pred_target  input  32  meaning target that was predicted for this branch.
REQ-017 Port mispredict  output  1  meaning one-cycle flush/redirect pulse.
REQ-018 Port redirect_pc  output  32  meaning corrected PC, valid while mispredict=1.
REQ-019 Port mp_count  output  CNT_W  meaning saturating count of mispredictions since reset.

Function
REQ-020 Entry fields SHALL be: valid, tag = PC[31:IDX+1], target[31:0], ctr[1:0]; index = PC[IDX:1], where IDX = log2(ENTRIES).
REQ-021 Counter encoding SHALL be: 00 strong-not-taken, 01 weak-not-taken, 10 weak-taken, 11 strong-taken.
REQ-022 Lookup latency SHALL be 1 cycle: pred_valid in cycle N+1 equals lk_valid in cycle N.
REQ-023 Hit SHALL be defined as valid && tag match; pred_taken = hit && ctr[1]; pred_target = stored target if pred_taken, else 0.
REQ-024 On rs_valid with hit: rs_taken=1 increments ctr, saturating at 11; rs_taken=0 decrements ctr, saturating at 00; target is rewritten with rs_target when rs_taken=1.
REQ-025 On rs_valid with miss and rs_taken=1: the entry is allocated (overwriting any existing entry) with valid=1, the new tag, target=rs_target, ctr=10.
REQ-026 On rs_valid with miss and rs_taken=0: no table change.
REQ-027 Misprediction condition: rs_valid && (rs_taken != rs_pred_taken || (rs_taken && rs_pred_target != rs_target)).
REQ-028 mispredict SHALL be registered, asserting in the cycle after the misprediction condition, for exactly one cycle per resolved branch.
REQ-029 redirect_pc SHALL equal rs_target if rs_taken, else rs_fallthrough; it SHALL be 0 when mispredict=0.
REQ-030 mp_count SHALL increment by 1 per misprediction and hold at all-ones (no wrap).
REQ-031 Same-cycle lookup and update to the same index SHALL be read-before-write: the lookup returns pre-update contents.
REQ-032 Back-to-back rs_valid cycles SHALL each be processed; there is no stall or backpressure.
REQ-033 lk_valid=0 SHALL drive pred_valid=0, pred_taken=0, and pred_target=0 in the next cycle.

Reset
REQ-034 While rst=1 at a clock edge, all entries SHALL be cleared to valid=0 and ctr=01, and pred_valid, pred_taken, pred_target, mispredict, redirect_pc, and mp_count SHALL be cleared to 0.
REQ-035 Reset asserted mid-operation SHALL discard in-flight lookups and updates; the first lookup after rst falls SHALL miss.

Verification
REQ-036 After reset, lk_pc=0x100 -> next cycle pred_valid=1, pred_taken=0, pred_target=0.
REQ-037 Resolve pc=0x100, taken, target=0x80, pred_taken=0 -> mispredict=1 and redirect_pc=0x80 next cycle; a subsequent lookup of 0x100 gives pred_taken=1 and target 0x80.
REQ-038 Four resolves of 0x100 taken, then three not-taken -> ctr sequence 10,11,11,11,10,01,00; predictions follow ctr[1].
REQ-039 Resolve pc=0x100 not-taken, pred_taken=1, fallthrough=0x102 -> mispredict=1 and redirect_pc=0x102; a same-cycle lookup of 0x100 returns the old prediction.
REQ-040 Alias: allocate 0x100 then 0x120 (ENTRIES=16, same index) taken -> lookup of 0x100 misses; assert rst mid-sequence -> all lookups miss and mp_count=0.
REQ-041 Force 2^CNT_W+3 mispredictions (CNT_W=4 build) -> mp_count holds at 0xF.
